// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage in-order core.
// Sole driver of the four pipeline-register load enables. Detects RAW hazards
// between ID and every in-flight writer (no forwarding, no RF write-through),
// freezes the pipe while data memory completes an access, and holds all
// enables low for INIT_HOLD cycles after reset release.
//
// Parameters:
//   INIT_HOLD   - cycles after reset release with all enables low (1..255)
//   MEM_TIMEOUT - MEM_WAIT cycles before ST_mem_timeout is raised (1..255)
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   ID_rs1/rs2, *_used        ID-stage source registers and their use flags
//   IF_ID_vld                 ID holds a valid instruction
//   ID_EX/EX_MEM/MEM_WB_rd,   destinations and valids of in-flight writers
//   *_vld
//   EX_MEM_mem_cmd            bus command in MEM (2'b00 = no access)
//   DM_ready                  data memory completes the access this cycle
//   ST_*_en                   pipeline-register load enables
//   ST_id_ex_bubble           load a NOP into ID/EX
//   ST_mem_wb_bubble          load an invalid entry into MEM/WB
//   ST_mem_timeout            sticky: a memory wait exceeded MEM_TIMEOUT
//
// Optional feature (macro STALL_PERF_CNT_EN): adds ST_raw_cnt / ST_mem_cnt,
// 32-bit wrapping counts of cycles with ST_id_ex_bubble / ST_mem_wb_bubble.
module hazard_ctrl #(
  parameter int unsigned INIT_HOLD   = 4,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_rs1_used,
  input  logic        ID_rs2_used,
  input  logic        IF_ID_vld,
  input  logic [4:0]  ID_EX_rd,
  input  logic        ID_EX_vld,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_vld,
  input  logic [1:0]  EX_MEM_mem_cmd,
  input  logic [4:0]  MEM_WB_rd,
  input  logic        MEM_WB_vld,
  input  logic        DM_ready,
  output logic        ST_if_id_en,
  output logic        ST_id_ex_en,
  output logic        ST_ex_mem_en,
  output logic        ST_mem_wb_en,
  output logic        ST_id_ex_bubble,
  output logic        ST_mem_wb_bubble,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0] ST_raw_cnt,
  output logic [31:0] ST_mem_cnt,
`endif
  output logic        ST_mem_timeout
);

  localparam logic [1:0] S_INIT     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;

  localparam logic [1:0] BUS_NONE = 2'b00;

  localparam logic [7:0] INIT_LAST   = 8'(INIT_HOLD - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  logic [1:0] state, state_nxt;
  logic [7:0] init_cnt;
  logic [7:0] wait_cnt;

  logic mem_access, mem_stall;
  logic match_rs1, match_rs2, raw;

  assign mem_access = EX_MEM_vld && (EX_MEM_mem_cmd != BUS_NONE);
  assign mem_stall  = mem_access && !DM_ready;

  // x0 is hardwired zero, so it never aliases an in-flight writer.
  assign match_rs1 = (ID_rs1 != '0) &&
                     ((ID_EX_vld  && (ID_rs1 == ID_EX_rd))  ||
                      (EX_MEM_vld && (ID_rs1 == EX_MEM_rd)) ||
                      (MEM_WB_vld && (ID_rs1 == MEM_WB_rd)));
  assign match_rs2 = (ID_rs2 != '0) &&
                     ((ID_EX_vld  && (ID_rs2 == ID_EX_rd))  ||
                      (EX_MEM_vld && (ID_rs2 == EX_MEM_rd)) ||
                      (MEM_WB_vld && (ID_rs2 == MEM_WB_rd)));
  assign raw = IF_ID_vld && ((ID_rs1_used && match_rs1) ||
                             (ID_rs2_used && match_rs2));

  // Enables are combinational so a stall bites in the cycle it is detected.
  always_comb begin
    ST_if_id_en      = 1'b0;
    ST_id_ex_en      = 1'b0;
    ST_ex_mem_en     = 1'b0;
    ST_mem_wb_en     = 1'b0;
    ST_id_ex_bubble  = 1'b0;
    ST_mem_wb_bubble = 1'b0;
    if (state != S_INIT) begin
      if (mem_stall) begin
        ST_mem_wb_en     = 1'b1;
        ST_mem_wb_bubble = 1'b1;
      end else if (raw) begin
        ST_id_ex_en     = 1'b1;
        ST_id_ex_bubble = 1'b1;
        ST_ex_mem_en    = 1'b1;
        ST_mem_wb_en    = 1'b1;
      end else begin
        ST_if_id_en  = 1'b1;
        ST_id_ex_en  = 1'b1;
        ST_ex_mem_en = 1'b1;
        ST_mem_wb_en = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:     if (init_cnt == INIT_LAST) state_nxt = S_RUN;
      S_RUN:      if (mem_stall)             state_nxt = S_MEM_WAIT;
      S_MEM_WAIT: if (!mem_stall)            state_nxt = S_RUN;
      default:                               state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_INIT;
      init_cnt       <= '0;
      wait_cnt       <= '0;
      ST_mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) init_cnt <= init_cnt + 8'd1;
      if (state == S_RUN && mem_stall) begin
        wait_cnt <= '0;
      end else if (state == S_MEM_WAIT && mem_stall && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (state == S_MEM_WAIT && wait_cnt == TIMEOUT_CNT) ST_mem_timeout <= 1'b1;
    end
  end

`ifdef STALL_PERF_CNT_EN
  // Bubbles are forced low in INIT, so INIT cycles are never counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ST_raw_cnt <= '0;
      ST_mem_cnt <= '0;
    end else begin
      if (ST_id_ex_bubble)  ST_raw_cnt <= ST_raw_cnt + 32'd1;
      if (ST_mem_wb_bubble) ST_mem_cnt <= ST_mem_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam logic [5:0] O_OFF = 6'b000000;
  localparam logic [5:0] O_RUN = 6'b111100;
  localparam logic [5:0] O_RAW = 6'b011110;
  localparam logic [5:0] O_MEM = 6'b000101;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ID_rs1, ID_rs2, ID_EX_rd, EX_MEM_rd, MEM_WB_rd;
  logic       ID_rs1_used, ID_rs2_used, IF_ID_vld, ID_EX_vld, EX_MEM_vld;
  logic       MEM_WB_vld, DM_ready;
  logic [1:0] EX_MEM_mem_cmd;
  logic       ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en;
  logic       ST_id_ex_bubble, ST_mem_wb_bubble, ST_mem_timeout;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] ST_raw_cnt, ST_mem_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.INIT_HOLD(4), .MEM_TIMEOUT(2)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .IF_ID_vld(IF_ID_vld),
    .ID_EX_rd(ID_EX_rd), .ID_EX_vld(ID_EX_vld),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_vld(EX_MEM_vld),
    .EX_MEM_mem_cmd(EX_MEM_mem_cmd),
    .MEM_WB_rd(MEM_WB_rd), .MEM_WB_vld(MEM_WB_vld),
    .DM_ready(DM_ready),
    .ST_if_id_en(ST_if_id_en), .ST_id_ex_en(ST_id_ex_en),
    .ST_ex_mem_en(ST_ex_mem_en), .ST_mem_wb_en(ST_mem_wb_en),
    .ST_id_ex_bubble(ST_id_ex_bubble), .ST_mem_wb_bubble(ST_mem_wb_bubble),
`ifdef STALL_PERF_CNT_EN
    .ST_raw_cnt(ST_raw_cnt), .ST_mem_cnt(ST_mem_cnt),
`endif
    .ST_mem_timeout(ST_mem_timeout)
  );

  logic [5:0] outs;
  assign outs = {ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en,
                 ST_id_ex_bubble, ST_mem_wb_bubble};

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2, ifv;
    logic [4:0] exrd;  logic exv;
    logic [4:0] memrd; logic memv; logic [1:0] cmd;
    logic [4:0] wbrd;  logic wbv;
    logic       rdy;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [4:0] rs1, rs2, input logic u1, u2, ifv,
                              input logic [4:0] exrd, input logic exv,
                              input logic [4:0] memrd, input logic memv,
                              input logic [1:0] cmd,
                              input logic [4:0] wbrd, input logic wbv,
                              input logic rdy, input logic [5:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.ifv = ifv;
    v.exrd = exrd; v.exv = exv; v.memrd = memrd; v.memv = memv; v.cmd = cmd;
    v.wbrd = wbrd; v.wbv = wbv; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    ID_rs1 = '0; ID_rs2 = '0; ID_rs1_used = 0; ID_rs2_used = 0; IF_ID_vld = 0;
    ID_EX_rd = '0; ID_EX_vld = 0; EX_MEM_rd = '0; EX_MEM_vld = 0;
    EX_MEM_mem_cmd = '0; MEM_WB_rd = '0; MEM_WB_vld = 0; DM_ready = 1;
  endtask

  task automatic apply(input vec_t v);
    ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_rs1_used = v.u1; ID_rs2_used = v.u2;
    IF_ID_vld = v.ifv; ID_EX_rd = v.exrd; ID_EX_vld = v.exv;
    EX_MEM_rd = v.memrd; EX_MEM_vld = v.memv; EX_MEM_mem_cmd = v.cmd;
    MEM_WB_rd = v.wbrd; MEM_WB_vld = v.wbv; DM_ready = v.rdy;
  endtask

  // Called just after reset release at a negedge with idle inputs.
  task automatic init_seq(input string tag);
    #1 chk({tag, "_init0"}, 32'(outs), 32'(O_OFF));
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_init_edge%0d", tag, k), 32'(outs),
          32'((k == 4) ? O_RUN : O_OFF));
    end
  endtask

  initial begin
    //              rs1 rs2 u1 u2 ifv exrd exv memrd memv cmd wbrd wbv rdy exp
    vecs[0]  = mk(0,  0,  0, 0, 0,  0, 0,  0, 0, 2'd0,  0, 0, 1, O_RUN);
    vecs[1]  = mk(5,  0,  1, 0, 1,  5, 1,  0, 0, 2'd0,  0, 0, 1, O_RAW);
    vecs[2]  = mk(0,  0,  0, 1, 1,  0, 1,  0, 0, 2'd0,  0, 0, 1, O_RUN);
    vecs[3]  = mk(0,  7,  0, 0, 1,  0, 0,  7, 1, 2'd0,  0, 0, 1, O_RUN);
    vecs[4]  = mk(0,  7,  0, 1, 1,  0, 0,  7, 1, 2'd0,  0, 0, 1, O_RAW);
    vecs[5]  = mk(9,  0,  1, 0, 1,  0, 0,  0, 0, 2'd0,  9, 1, 1, O_RAW);
    vecs[6]  = mk(9,  0,  1, 0, 1,  0, 0,  0, 0, 2'd0,  9, 0, 1, O_RUN);
    vecs[7]  = mk(5,  0,  1, 0, 0,  5, 1,  0, 0, 2'd0,  0, 0, 1, O_RUN);
    vecs[8]  = mk(0,  0,  0, 0, 0,  0, 0,  4, 1, 2'd1,  0, 0, 0, O_MEM);
    vecs[9]  = mk(0,  0,  0, 0, 0,  0, 0,  4, 1, 2'd2,  0, 0, 1, O_RUN);
    vecs[10] = mk(0,  0,  0, 0, 0,  0, 0,  4, 0, 2'd1,  0, 0, 0, O_RUN);
    vecs[11] = mk(3,  0,  1, 0, 1,  0, 0,  3, 1, 2'd1,  0, 0, 0, O_MEM);
    vecs[12] = mk(3,  0,  1, 0, 1,  0, 0,  3, 1, 2'd1,  0, 0, 1, O_RAW);
    vecs[13] = mk(31, 0,  1, 0, 1, 30, 1,  0, 0, 2'd0,  0, 0, 1, O_RUN);

    rst = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(outs), 32'(O_OFF));
    chk("reset_timeout", 32'(ST_mem_timeout), 32'd0);
`ifdef STALL_PERF_CNT_EN
    chk("reset_raw_cnt", ST_raw_cnt, 32'd0);
    chk("reset_mem_cnt", ST_mem_cnt, 32'd0);
`endif
    @(negedge clk) rst = 1'b1;
    init_seq("first");

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1 chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
    end

    // RAW on x5 retiring through EX, MEM, WB.
    @(negedge clk) idle();
    ID_rs1 = 5; ID_rs1_used = 1; IF_ID_vld = 1; ID_EX_rd = 5; ID_EX_vld = 1;
    #1 chk("retire_ex", 32'(outs), 32'(O_RAW));
    @(negedge clk) ID_EX_vld = 0; EX_MEM_rd = 5; EX_MEM_vld = 1;
    #1 chk("retire_mem", 32'(outs), 32'(O_RAW));
    @(negedge clk) EX_MEM_vld = 0; MEM_WB_rd = 5; MEM_WB_vld = 1;
    #1 chk("retire_wb", 32'(outs), 32'(O_RAW));
    @(negedge clk) MEM_WB_vld = 0;
    #1 chk("retire_done", 32'(outs), 32'(O_RUN));

    // Load waits three cycles, completes on the fourth.
    @(negedge clk) idle();
    EX_MEM_vld = 1; EX_MEM_mem_cmd = 2'd1; DM_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("load_wait%0d", c), 32'(outs), 32'(O_MEM));
      @(negedge clk);
    end
    DM_ready = 1;
    #1 chk("load_done", 32'(outs), 32'(O_RUN));

    // Fresh reset, then a long wait with a concurrent RAW.
    @(negedge clk) idle(); rst = 1'b0;
    #1 chk("pulse_timeout_clr", 32'(ST_mem_timeout), 32'd0);
    @(negedge clk) rst = 1'b1;
    init_seq("second");
    @(negedge clk);
    ID_rs1 = 3; ID_rs1_used = 1; IF_ID_vld = 1;
    EX_MEM_rd = 3; EX_MEM_vld = 1; EX_MEM_mem_cmd = 2'd1; DM_ready = 0;
    #1 chk("to_flag_start", 32'(ST_mem_timeout), 32'd0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("to_stall%0d", c), 32'(outs), 32'(O_MEM));
      @(posedge clk); #1;
    end
    chk("to_flag_set", 32'(ST_mem_timeout), 32'd1);
    @(negedge clk) DM_ready = 1;
    #1 chk("to_ready_raw", 32'(outs), 32'(O_RAW));
    @(negedge clk) idle();
    #1 chk("to_run", 32'(outs), 32'(O_RUN));
    chk("to_flag_sticky", 32'(ST_mem_timeout), 32'd1);

    // Asynchronous reset while stalled in MEM_WAIT.
    @(negedge clk);
    EX_MEM_vld = 1; EX_MEM_mem_cmd = 2'd2; DM_ready = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("async_rst_outs", 32'(outs), 32'(O_OFF));
    chk("async_rst_timeout", 32'(ST_mem_timeout), 32'd0);
`ifdef STALL_PERF_CNT_EN
    chk("async_rst_raw_cnt", ST_raw_cnt, 32'd0);
    chk("async_rst_mem_cnt", ST_mem_cnt, 32'd0);
`endif
    @(negedge clk) idle(); rst = 1'b1;
    init_seq("third");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
